// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the boot loader: FSM state encodings (3-bit)
//   and stream/word width constants.
package rom_loader_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        ST_LEN_LO  = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader
//   Boot-time program loader and instruction-memory arbiter. Holds the CPU in
//   reset while a byte stream (16-bit little-endian word count, then
//   little-endian 16-bit words) is written into instruction RAM from address
//   0, then releases the CPU and hands the RAM address port to the CPU fetch
//   address.
//
// Ports
//   clk, reset        system clock (rising edge), async active-high reset
//   start_i           reload request, honoured in RUN and ERROR
//   rx_valid_i/data_i byte stream in; rx_ready_o accepts
//   cpu_addr_i        CPU next-instruction address
//   rom_addr_o        RAM address (cpu_addr_i in RUN, else word_addr)
//   rom_we_o          RAM write enable (WRITE state only)
//   rom_data_o        RAM write data {hi, lo}
//   cpu_reset_o       CPU reset, high outside RUN
//   loading_o         high outside RUN and ERROR
//   error_o           high in ERROR (word count too large)
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_LEN_LO  | wait for word count low byte
// ST_LEN_HI  | wait for word count high byte, validate count
// ST_DATA_LO | wait for instruction low byte
// ST_DATA_HI | wait for instruction high byte
// ST_WRITE   | one-cycle RAM write of {hi, lo} at word_addr
// ST_RUN     | CPU running, fetch address passed through
// ST_ERROR   | count exceeded memory size, CPU held in reset
//
// ADDR_WIDTH must be 15 or less so the count fits the 16-bit length field.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  rx_valid_i,
    input  logic [BYTE_WIDTH-1:0] rx_data_i,
    output logic                  rx_ready_o,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_we_o,
    output logic [WORD_WIDTH-1:0] rom_data_o,
    output logic                  cpu_reset_o,
    output logic                  loading_o,
    output logic                  error_o
);

    localparam logic [16:0] LEN_LIMIT = 17'(1) << ADDR_WIDTH;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [15:0]             len;
    logic [BYTE_WIDTH-1:0]   lo_byte;
    logic [BYTE_WIDTH-1:0]   hi_byte;

    logic                    rx_fire;
    logic [15:0]             len_next;
    logic [ADDR_WIDTH:0]     len_last;

    assign rx_fire  = rx_valid_i && rx_ready_o;
    assign len_next = {rx_data_i, len[7:0]};
    // One bit wider than word_addr so a full-memory count ends on the last
    // address instead of wrapping.
    assign len_last = len[ADDR_WIDTH:0] - (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LEN_LO;
            word_addr <= '0;
            len       <= '0;
            lo_byte   <= '0;
            hi_byte   <= '0;
        end else begin
            case (state)
                ST_LEN_LO: begin
                    if (rx_fire) begin
                        len[7:0] <= rx_data_i;
                        state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_fire) begin
                        len[15:8] <= rx_data_i;
                        if (len_next == 16'd0) begin
                            state <= ST_RUN;
                        end else if ({1'b0, len_next} > LEN_LIMIT) begin
                            state <= ST_ERROR;
                        end else begin
                            word_addr <= '0;
                            state     <= ST_DATA_LO;
                        end
                    end
                end
                ST_DATA_LO: begin
                    if (rx_fire) begin
                        lo_byte <= rx_data_i;
                        state   <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (rx_fire) begin
                        hi_byte <= rx_data_i;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if ({1'b0, word_addr} == len_last) begin
                        state <= ST_RUN;
                    end else begin
                        word_addr <= word_addr + ADDR_WIDTH'(1);
                        state     <= ST_DATA_LO;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    // Clearing here makes the RAM address read 0 as soon as
                    // arbitration leaves the CPU.
                    if (start_i) begin
                        word_addr <= '0;
                        state     <= ST_LEN_LO;
                    end
                end
                default: state <= ST_LEN_LO;
            endcase
        end
    end

    assign rx_ready_o  = (state == ST_LEN_LO)  || (state == ST_LEN_HI) ||
                         (state == ST_DATA_LO) || (state == ST_DATA_HI);
    assign rom_we_o    = (state == ST_WRITE);
    assign rom_addr_o  = (state == ST_RUN) ? cpu_addr_i : word_addr;
    assign rom_data_o  = {hi_byte, lo_byte};
    assign cpu_reset_o = (state != ST_RUN);
    assign loading_o   = (state != ST_RUN) && (state != ST_ERROR);
    assign error_o     = (state == ST_ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
//   Scoreboard bench for rom_loader: stimulus pushes expected RAM writes into
//   a queue, an independent monitor pops and compares on every write pulse.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic [14:0] cpu_addr_i;
    logic [14:0] rom_addr_o;
    logic        rom_we_o;
    logic [15:0] rom_data_o;
    logic        cpu_reset_o;
    logic        loading_o;
    logic        error_o;

    int cmp_count = 0;
    int err_count = 0;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] wbuf[$];
    logic [15:0] model_mem[int];
    logic [15:0] tb_ram[0:32767];

    always #5 clk = ~clk;

    rom_loader #(.ADDR_WIDTH(15), .WORD_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .cpu_addr_i  (cpu_addr_i),
        .rom_addr_o  (rom_addr_o),
        .rom_we_o    (rom_we_o),
        .rom_data_o  (rom_data_o),
        .cpu_reset_o (cpu_reset_o),
        .loading_o   (loading_o),
        .error_o     (error_o)
    );

    // Instruction RAM stand-in
    always @(posedge clk) begin
        if (rom_we_o && !reset) tb_ram[rom_addr_o] <= rom_data_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write pulse against the scoreboard and checks
    // CPU release on the cycle after the final write.
    bit prev_we = 1'b0;
    bit release_pending = 1'b0;
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_we = 1'b0;
                release_pending = 1'b0;
            end else begin
                if (release_pending) begin
                    check("release_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
                    check("release_loading", {31'd0, loading_o}, 32'd0);
                    check("release_addr_pass", {17'd0, rom_addr_o}, {17'd0, cpu_addr_i});
                    release_pending = 1'b0;
                end
                if (rom_we_o) begin
                    check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                    check("we_cpu_held", {31'd0, cpu_reset_o}, 32'd1);
                    if (sb.size() == 0) begin
                        cmp_count++;
                        err_count++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", rom_addr_o, rom_data_o);
                    end else begin
                        e = sb.pop_front();
                        check("write_addr", {17'd0, rom_addr_o}, {17'd0, e.addr});
                        check("write_data", {16'd0, rom_data_o}, {16'd0, e.data});
                        if (e.last) release_pending = 1'b1;
                    end
                end
                prev_we = rom_we_o;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        n = 0;
        repeat (gap) begin
            rx_data_i = 8'($urandom);
            @(negedge clk);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        while (!rx_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("rx_ready_timeout", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk);
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    // Sends count len and the first nsend words of wbuf; expected writes
    // follow directly from the stream: word i lands at address i.
    task automatic load(input int len, input int nsend, input int max_gap);
        for (int i = 0; i < nsend; i++) begin
            wr_t e;
            e.addr = 15'(i);
            e.data = wbuf[i];
            e.last = (i == len - 1);
            sb.push_back(e);
            model_mem[i] = wbuf[i];
        end
        send_byte(8'(len), max_gap);
        send_byte(8'(len >> 8), max_gap);
        for (int i = 0; i < nsend; i++) begin
            send_byte(wbuf[i][7:0], max_gap);
            send_byte(wbuf[i][15:8], max_gap);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    task automatic wait_run_and_check();
        int n = 0;
        while (cpu_reset_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("reach_run", {31'd0, cpu_reset_o}, 32'd0);
        cpu_addr_i = 15'($urandom);
        #1;
        check("run_addr_pass", {17'd0, rom_addr_o}, {17'd0, cpu_addr_i});
        check("run_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        check("run_error", {31'd0, error_o}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("reload_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("reload_addr_zero", {17'd0, rom_addr_o}, 32'd0);
        check("reload_loading", {31'd0, loading_o}, 32'd1);
        check("reload_error", {31'd0, error_o}, 32'd0);
    endtask

    task automatic compare_mem();
        foreach (model_mem[a]) check("mem_contents", {16'd0, tb_ram[a]}, {16'd0, model_mem[a]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        cpu_addr_i = 15'h1555;

        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("rst_we", {31'd0, rom_we_o}, 32'd0);
        check("rst_addr", {17'd0, rom_addr_o}, 32'd0);
        check("rst_data", {16'd0, rom_data_o}, 32'd0);
        check("rst_loading", {31'd0, loading_o}, 32'd1);
        check("rst_error", {31'd0, error_o}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Basic load
        wbuf = '{16'h1234, 16'hABCD};
        load(2, 2, 0);
        wait_drain();
        wait_run_and_check();
        // Bytes offered in RUN are ignored
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h5A;
        repeat (3) @(negedge clk);
        #1;
        check("run_ignores_bytes", {31'd0, cpu_reset_o}, 32'd0);
        rx_valid_i = 1'b0;
        compare_mem();

        // Zero length
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        #1;
        check("zero_len_run", {31'd0, cpu_reset_o}, 32'd0);
        check("zero_len_not_error", {31'd0, error_o}, 32'd0);

        // Over-length
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h80, 0);
        #1;
        check("ovl_error", {31'd0, error_o}, 32'd1);
        check("ovl_cpu_held", {31'd0, cpu_reset_o}, 32'd1);
        check("ovl_rx_ready", {31'd0, rx_ready_o}, 32'd0);
        check("ovl_loading", {31'd0, loading_o}, 32'd0);
        rx_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("ovl_ignores_bytes", {31'd0, error_o}, 32'd1);
        rx_valid_i = 1'b0;
        pulse_start();

        // Exactly full memory is accepted
        send_byte(8'h00, 0);
        send_byte(8'h80, 0);
        #1;
        check("full_len_not_error", {31'd0, error_o}, 32'd0);
        check("full_len_loading", {31'd0, rx_ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Backpressure, 4 words
        wbuf = '{};
        for (int i = 0; i < 4; i++) wbuf.push_back(16'($urandom));
        load(4, 4, 3);
        wait_drain();
        wait_run_and_check();
        compare_mem();

        // Reset mid-load after 1 of 3 words
        pulse_start();
        wbuf = '{};
        for (int i = 0; i < 3; i++) wbuf.push_back(16'($urandom));
        load(3, 1, 1);
        wait_drain();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
        check("midrst_addr", {17'd0, rom_addr_o}, 32'd0);
        check("midrst_loading", {31'd0, loading_o}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wbuf = '{16'($urandom)};
        load(1, 1, 0);
        wait_drain();
        wait_run_and_check();
        compare_mem();

        // Reload from RUN overwrites word 0 only
        pulse_start();
        wbuf = '{16'($urandom)};
        load(1, 1, 2);
        wait_drain();
        wait_run_and_check();
        compare_mem();

        // Random loads
        for (int t = 0; t < 4; t++) begin
            int n;
            n = int'($urandom_range(6, 1));
            pulse_start();
            wbuf = '{};
            for (int i = 0; i < n; i++) wbuf.push_back(16'($urandom));
            load(n, n, int'($urandom_range(2, 0)));
            wait_drain();
            wait_run_and_check();
        end
        compare_mem();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
